// File: rtl/operand_read_pkg.sv
// operand_read_pkg: types and sizes shared by dispatch, operand read and
// writeback.
//   NREGS         - architectural register count (reg 0 reads as zero)
//   DATA_W        - register data width
//   regbits_t     - register index
//   word_t        - register data word
//   operand_pkt_t - contents of the operand output stage
package operand_read_pkg;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = $clog2(NREGS);

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        word_t    rs1_dat;
        word_t    rs2_dat;
        regbits_t rd;
        logic     rd_en;
        logic     spec;
    } operand_pkt_t;

endpackage

// File: rtl/operand_read_if.sv
// operand_read_if: bundles the dispatch, writeback, branch-resolution and
// operand-output signals of the operand reader.
//   master - environment side: drives dispatch/writeback/branch/op_ready
//   slave  - operand_read side: drives disp_ready and the op_* outputs
interface operand_read_if;
    import operand_read_pkg::*;

    // Dispatch
    logic     disp_valid;
    logic     disp_ready;
    regbits_t disp_rs1;
    regbits_t disp_rs2;
    regbits_t disp_rd;
    logic     disp_rd_en;
    logic     disp_spec;

    // Writeback
    logic     wb_en;
    regbits_t wb_reg_sel;
    word_t    wb_wdat;

    // Branch resolution pulses
    logic     branch_correct;
    logic     branch_mispredict;

    // Operand output stage
    logic     op_valid;
    logic     op_ready;
    word_t    op_rs1_dat;
    word_t    op_rs2_dat;
    regbits_t op_rd;
    logic     op_rd_en;
    logic     op_spec;

    modport master (
        output disp_valid, disp_rs1, disp_rs2, disp_rd, disp_rd_en, disp_spec,
        output wb_en, wb_reg_sel, wb_wdat,
        output branch_correct, branch_mispredict,
        output op_ready,
        input  disp_ready,
        input  op_valid, op_rs1_dat, op_rs2_dat, op_rd, op_rd_en, op_spec
    );

    modport slave (
        input  disp_valid, disp_rs1, disp_rs2, disp_rd, disp_rd_en, disp_spec,
        input  wb_en, wb_reg_sel, wb_wdat,
        input  branch_correct, branch_mispredict,
        input  op_ready,
        output disp_ready,
        output op_valid, op_rs1_dat, op_rs2_dat, op_rd, op_rd_en, op_spec
    );

endinterface

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: pending-write scoreboard with speculation tracking.
//   clk_i, rst_i         - clock, synchronous active-high reset
//   set_en_i/idx/spec    - mark a register pending (and whether speculative)
//   clr_en_i/clr_idx_i   - writeback retires a pending register
//   commit_i             - branch resolved correctly: speculation becomes real
//   squash_i             - branch mispredicted: drop speculative pendings
//   query_idx_i          - three lookup indices (rs1, rs2, rd)
//   eff_pending_o        - pending and not being written back this cycle
module operand_scoreboard
    import operand_read_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_en_i,
    input  regbits_t            set_idx_i,
    input  logic                set_spec_i,
    input  logic                clr_en_i,
    input  regbits_t            clr_idx_i,
    input  logic                commit_i,
    input  logic                squash_i,
    input  regbits_t [2:0]      query_idx_i,
    output logic     [2:0]      eff_pending_o
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [NREGS-1:0] spec_mask_q, spec_mask_d;

    always_comb begin
        pending_d   = pending_q;
        spec_mask_d = spec_mask_q;

        if (clr_en_i) begin
            pending_d[clr_idx_i]   = 1'b0;
            spec_mask_d[clr_idx_i] = 1'b0;
        end

        // Mispredict outranks a simultaneous correct-resolution pulse.
        if (squash_i) begin
            pending_d   = pending_d & ~spec_mask_q;
            spec_mask_d = '0;
        end else if (commit_i) begin
            spec_mask_d = '0;
        end

        // A new claim on the register beats a writeback retiring it.
        if (set_en_i && (set_idx_i != '0)) begin
            pending_d[set_idx_i]   = 1'b1;
            spec_mask_d[set_idx_i] = set_spec_i;
        end

        pending_d[0]   = 1'b0;
        spec_mask_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            spec_mask_q <= '0;
        end else begin
            pending_q   <= pending_d;
            spec_mask_q <= spec_mask_d;
        end
    end

    // A register retiring this very cycle is forwarded, so it is not a hazard.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eff_pending_o[i] = pending_q[query_idx_i[i]] &&
                               !(clr_en_i && (clr_idx_i == query_idx_i[i]));
        end
    end

endmodule

// File: rtl/operand_read.sv
// operand_read: issue-side register-file reader.
//   clk_i - clock, all state updates on the rising edge
//   rst_i - synchronous active-high reset
//   bus   - operand_read_if.slave: dispatch in, writeback in, branch pulses
//           in, one-entry valid/ready operand output stage out
// Owns the 32x32 register file, forwards same-cycle writeback data to the
// operand reads, and stalls dispatch on RAW/WAW hazards via the scoreboard.
module operand_read
    import operand_read_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    operand_read_if.slave bus
);

    word_t        regs_q [NREGS];
    word_t        rs1_dat;
    word_t        rs2_dat;
    logic [2:0]   eff_pending;
    logic         stall;
    logic         accept;
    logic         op_valid_q, op_valid_d;
    operand_pkt_t op_pkt_q, op_pkt_d;

    // Register file; index 0 is never written so it always reads zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_reg_sel != '0)) begin
            regs_q[bus.wb_reg_sel] <= bus.wb_wdat;
        end
    end

    // Same-cycle writeback bypass.
    always_comb begin
        if (bus.wb_en && (bus.wb_reg_sel == bus.disp_rs1) && (bus.disp_rs1 != '0)) begin
            rs1_dat = bus.wb_wdat;
        end else begin
            rs1_dat = regs_q[bus.disp_rs1];
        end
        if (bus.wb_en && (bus.wb_reg_sel == bus.disp_rs2) && (bus.disp_rs2 != '0)) begin
            rs2_dat = bus.wb_wdat;
        end else begin
            rs2_dat = regs_q[bus.disp_rs2];
        end
    end

    operand_scoreboard u_scoreboard (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .set_en_i      (accept && bus.disp_rd_en),
        .set_idx_i     (bus.disp_rd),
        .set_spec_i    (bus.disp_spec),
        .clr_en_i      (bus.wb_en),
        .clr_idx_i     (bus.wb_reg_sel),
        .commit_i      (bus.branch_correct),
        .squash_i      (bus.branch_mispredict),
        .query_idx_i   ({bus.disp_rd, bus.disp_rs2, bus.disp_rs1}),
        .eff_pending_o (eff_pending)
    );

    assign stall = eff_pending[0] || eff_pending[1] || (bus.disp_rd_en && eff_pending[2]);

    // Dispatch is held off during branch resolution so squash never races an accept.
    assign bus.disp_ready = !stall && !bus.branch_correct && !bus.branch_mispredict &&
                            (!op_valid_q || bus.op_ready);
    assign accept = bus.disp_valid && bus.disp_ready;

    always_comb begin
        op_valid_d = op_valid_q;
        op_pkt_d   = op_pkt_q;
        if (accept) begin
            op_valid_d       = 1'b1;
            op_pkt_d.rs1_dat = rs1_dat;
            op_pkt_d.rs2_dat = rs2_dat;
            op_pkt_d.rd      = bus.disp_rd;
            op_pkt_d.rd_en   = bus.disp_rd_en;
            op_pkt_d.spec    = bus.disp_spec;
        end else if (op_valid_q && !bus.op_ready) begin
            if (bus.branch_mispredict) begin
                if (op_pkt_q.spec) begin
                    op_valid_d = 1'b0;
                end
            end else if (bus.branch_correct) begin
                op_pkt_d.spec = 1'b0;
            end
        end else begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_valid_q <= 1'b0;
            op_pkt_q   <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_pkt_q   <= op_pkt_d;
        end
    end

    assign bus.op_valid   = op_valid_q;
    assign bus.op_rs1_dat = op_pkt_q.rs1_dat;
    assign bus.op_rs2_dat = op_pkt_q.rs2_dat;
    assign bus.op_rd      = op_pkt_q.rd;
    assign bus.op_rd_en   = op_pkt_q.rd_en;
    assign bus.op_spec    = op_pkt_q.spec;

endmodule
